// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// and buffers each fetched word (plus one pending word) for the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_ID_Wr,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC_out,
  output logic [31:0] PC_plus4
);

  // state   | meaning
  // IDLE    | no request; fetch starts next cycle
  // FETCH   | request to imem_addr outstanding
  // STALL   | buffer and pending entry full, no request
  // DISCARD | stale request outstanding after redirect; its data is dropped
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcout_q, pcout_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] pend_inst_q, pend_inst_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        drain;
  logic        launch;

  assign drain = !valid_q || IF_ID_Wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      pcout_q     <= '0;
      pcp4_q      <= '0;
      pend_inst_q <= '0;
      pend_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      pcout_q     <= pcout_d;
      pcp4_q      <= pcp4_d;
      pend_inst_q <= pend_inst_d;
      pend_pc_q   <= pend_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH: begin
        if (redirect_en)         state_d = imem_ack ? S_FETCH : S_DISCARD;
        else if (imem_ack && !drain) state_d = S_STALL;
      end
      S_STALL:   if (redirect_en || IF_ID_Wr) state_d = S_FETCH;
      S_DISCARD: if (imem_ack) state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    pcout_d     = pcout_q;
    pcp4_d      = pcp4_q;
    pend_inst_d = pend_inst_q;
    pend_pc_d   = pend_pc_q;
    launch      = 1'b0;

    if (valid_q && IF_ID_Wr) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: launch = 1'b1;
      S_FETCH: begin
        if (imem_ack) begin
          launch = 1'b1;
          pc_d   = pc_q + 32'd4;
          if (drain) begin
            valid_d = 1'b1;
            inst_d  = imem_rdata;
            pcout_d = pc_q;
            pcp4_d  = pc_q + 32'd4;
          end else begin
            launch      = 1'b0;
            pend_inst_d = imem_rdata;
            pend_pc_d   = pc_q;
          end
        end
      end
      S_STALL: begin
        if (IF_ID_Wr) begin
          launch  = 1'b1;
          valid_d = 1'b1;
          inst_d  = pend_inst_q;
          pcout_d = pend_pc_q;
          pcp4_d  = pend_pc_q + 32'd4;
        end
      end
      S_DISCARD: launch = imem_ack;
      default: launch = 1'b0;
    endcase

    // Redirect wins: buffer load and pending capture above are overridden.
    if (redirect_en) begin
      pc_d        = redirect_pc & 32'hFFFF_FFFC;
      valid_d     = 1'b0;
      inst_d      = inst_q;
      pcout_d     = pcout_q;
      pcp4_d      = pcp4_q;
      pend_inst_d = '0;
      pend_pc_d   = '0;
      launch      = (state_q != S_FETCH && state_q != S_DISCARD) || imem_ack;
    end

    if (launch) addr_d = pc_d;
  end

  always_comb begin
    imem_req    = (state_q == S_FETCH) || (state_q == S_DISCARD);
    imem_addr   = addr_q;
    inst_valid  = valid_q;
    Instruction = inst_q;
    PC_out      = pcout_q;
    PC_plus4    = pcp4_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized latency/back-pressure/redirects
// checked against a program-order model of which PC must be delivered next.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_ID_Wr;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] Instruction;
  logic [31:0] PC_out;
  logic [31:0] PC_plus4;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .IF_ID_Wr(IF_ID_Wr), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .Instruction(Instruction), .PC_out(PC_out), .PC_plus4(PC_plus4)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  bit          busy;
  int          cnt;
  int          fixed_lat;
  bit          prev_pend;
  logic [31:0] prev_addr;
  bit          want_v;
  logic [31:0] want_a;
  logic [31:0] exp_pc;
  bit          post_redir;
  int          consumed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy       = 1'b0;
    cnt        = 0;
    prev_pend  = 1'b0;
    want_v     = 1'b1;
    want_a     = RESET_PC;
    exp_pc     = RESET_PC;
    post_redir = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; IF_ID_Wr = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_pcout", PC_out, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle(input logic wr, input logic rd, input logic [31:0] rpc);
    logic ack;
    if (prev_pend) begin
      chk("req_held", imem_req, 1);
      chk("addr_held", imem_addr, prev_addr);
    end
    ack = 1'b0;
    if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        if (want_v) begin
          chk("first_req_addr", imem_addr, want_a);
          want_v = 1'b0;
        end
      end
      ack = (cnt == 0);
      if (!ack) cnt--;
    end
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(imem_addr) : $urandom;
    IF_ID_Wr    = wr;
    redirect_en = rd;
    redirect_pc = rpc;

    if (post_redir) chk("valid_after_redirect", inst_valid, 0);
    if (inst_valid) begin
      chk("pc_order", PC_out, exp_pc);
      chk("inst_data", Instruction, mem_word(PC_out));
      chk("pc_plus4", PC_plus4, PC_out + 32'd4);
    end
    if (inst_valid && wr) begin
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (rd) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
      want_v = 1'b1;
      want_a = rpc & 32'hFFFF_FFFC;
    end
    post_redir = rd;
    prev_pend  = imem_req && !ack;
    prev_addr  = imem_addr;

    @(posedge clk);
    if (ack) busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic        wr, rd;
    logic [31:0] rpc;

    // Reset, then zero-wait streaming
    fixed_lat = 0;
    do_reset();
    chk("idle_no_req", imem_req, 0);
    cycle(1, 0, 0);
    chk("start_req", imem_req, 1);
    chk("start_addr", imem_addr, RESET_PC);
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", inst_valid, 1);
      chk("stream_pc", PC_out, RESET_PC + 32'(4 * i));
      chk("stream_pcp4", PC_plus4, RESET_PC + 32'(4 * i + 4));
      cycle(1, 0, 0);
    end

    // Back-pressure: IF_ID_Wr low for 3 cycles after first valid word
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", inst_valid, 1);
      chk("stall_pc", PC_out, RESET_PC);
      if (i > 0) chk("stall_no_req", imem_req, 0);
      cycle(0, 0, 0);
    end
    chk("stall_held_pc", PC_out, RESET_PC);
    chk("stall_held_noreq", imem_req, 0);
    cycle(1, 0, 0);
    chk("release_pc", PC_out, RESET_PC + 32'd4);
    chk("release_req", imem_req, 1);
    chk("release_addr", imem_addr, RESET_PC + 32'd8);
    repeat (4) cycle(1, 0, 0);

    // Redirect while a slow request is outstanding
    fixed_lat = 3;
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h0040_0103);
    chk("discard_req", imem_req, 1);
    chk("discard_addr", imem_addr, RESET_PC);
    cycle(1, 0, 0);
    chk("discard_req2", imem_req, 1);
    chk("discard_addr2", imem_addr, RESET_PC);
    fixed_lat = 0;
    cycle(1, 0, 0);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h0040_0100);
    chk("redir_novalid", inst_valid, 0);
    repeat (3) cycle(1, 0, 0);

    // Redirect coinciding with an ack
    cycle(1, 1, 32'h0040_0200);
    chk("ackredir_valid", inst_valid, 0);
    chk("ackredir_addr", imem_addr, 32'h0040_0200);
    cycle(1, 0, 0);
    chk("ackredir_pc", PC_out, 32'h0040_0200);
    chk("ackredir_vld", inst_valid, 1);

    // Wrap at top of address space
    cycle(1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    chk("wrap_pc", PC_out, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PC_plus4, 32'h0000_0000);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);
    cycle(1, 0, 0);
    chk("wrap_pc0", PC_out, 32'h0000_0000);

    // Reset while STALL holds a pending word
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("pre_rst_stall", imem_req, 0);
    chk("pre_rst_valid", inst_valid, 1);
    reset = 1'b1; IF_ID_Wr = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("srst_req", imem_req, 0);
    chk("srst_valid", inst_valid, 0);
    chk("srst_inst", Instruction, 0);
    chk("srst_pcout", PC_out, 0);
    chk("srst_pcp4", PC_plus4, 0);
    chk("srst_addr", imem_addr, RESET_PC);
    reset = 1'b0;
    model_reset();
    cycle(1, 0, 0);
    chk("srst_restart", imem_req, 1);
    repeat (4) cycle(1, 0, 0);

    // Randomized latency, back-pressure and redirects
    fixed_lat = -1;
    do_reset();
    consumed = 0;
    for (int n = 0; n < 800; n++) begin
      wr = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : (32'h0040_0000 | ($urandom & 32'h0000_0FFF));
      cycle(wr, rd, rpc);
    end
    chk("random_progress", 32'(consumed >= 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
